result_packer: RTL and testbench

Output-side stage placed directly downstream of the convolution datapath. Accepts the 8-bit `result_data`/`result_valid` byte stream and packs four consecutive results little-endian into 32-bit words. Words are buffered in a small FIFO and written to output memory at sequential word addresses through a valid/ready write port. The datapath cannot be stalled, so FIFO overrun is flagged, never back-pressured.

---
 rtl/result_packer.sv | 231 +++++++++++++++++++++++
 tb/tb_result_packer.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/result_packer.sv
// result_packer: packs the 8-bit result stream little-endian into 32-bit words and
// writes them through a small FIFO. The optional byte counter is enabled by RESULT_PACKER_BYTECNT_EN.
module result_packer #(
  parameter int ADDR_WIDTH = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [7:0]            result_data,
  input  logic                  result_valid,
  input  logic                  flush,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [31:0]           wr_data,
  output logic [3:0]            wr_be,
  input  logic                  wr_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  fifo_ovrflow
`ifdef RESULT_PACKER_BYTECNT_EN
  ,
  output logic [ADDR_WIDTH+1:0] byte_count
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PACK  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  function automatic logic [3:0] lane_be(input logic [2:0] n);
    logic [3:0] be;
    case (n)
      3'd1:    be = 4'b0001;
      3'd2:    be = 4'b0011;
      3'd3:    be = 4'b0111;
      3'd4:    be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] be_mask(input logic [3:0] be);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) begin
      m[8*i +: 8] = {8{be[i]}};
    end
    return m;
  endfunction

`ifdef RESULT_PACKER_BYTECNT_EN
  function automatic logic [2:0] popcount4(input logic [3:0] v);
    return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
  endfunction
`endif

  state_t                state_r, state_nxt_s;
  logic                  done_r, done_nxt_s;
  logic [1:0]            lane_r, lane_nxt_s;
  logic [23:0]           bytes_r;
  logic [35:0]           mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]      rd_ptr_r, wr_ptr_r;
  logic [CNT_W-1:0]      count_r;
  logic [ADDR_WIDTH-1:0] wr_addr_r;
  logic                  ovf_r;

  logic        accept_s, flush_s, push_s, push_ok_s, pop_s, overflow_s;
  logic        fifo_empty_s, fifo_full_s;
  logic [2:0]  fill_s;
  logic [31:0] word_s;
  logic [35:0] push_word_s, head_s;

  assign accept_s     = (state_r == PACK) && result_valid && !start;
  assign flush_s      = (state_r == PACK) && flush && !start;
  assign fifo_empty_s = (count_r == '0);
  assign fifo_full_s  = (count_r == FULL_CNT);
  assign pop_s        = !fifo_empty_s && wr_ready && !start;
  assign push_ok_s    = push_s && (!fifo_full_s || pop_s);
  assign overflow_s   = push_s && fifo_full_s && !pop_s;
  assign head_s       = mem_r[rd_ptr_r];

  // Merge the incoming byte into the staged word and decide what, if anything, is pushed.
  always_comb begin
    word_s      = {8'h00, bytes_r};
    fill_s      = {1'b0, lane_r};
    push_s      = 1'b0;
    push_word_s = 36'h0;
    lane_nxt_s  = lane_r;
    if (accept_s) begin
      word_s[{lane_r, 3'b000} +: 8] = result_data;
      fill_s = {1'b0, lane_r} + 3'd1;
    end else begin
      fill_s = {1'b0, lane_r};
    end
    // A completed word wins over a same-cycle flush; the flush then sees lane 0.
    if (fill_s == 3'd4) begin
      push_s      = 1'b1;
      push_word_s = {4'hF, word_s};
      lane_nxt_s  = 2'd0;
    end else if (flush_s && (fill_s != 3'd0)) begin
      push_s      = 1'b1;
      push_word_s = {lane_be(fill_s), word_s & be_mask(lane_be(fill_s))};
      lane_nxt_s  = 2'd0;
    end else begin
      push_s      = 1'b0;
      push_word_s = 36'h0;
      lane_nxt_s  = fill_s[1:0];
    end
  end

  // FSM state register and registered done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      done_r  <= done_nxt_s;
    end
  end

  // FSM next-state logic; start overrides every state.
  always_comb begin
    state_nxt_s = state_r;
    done_nxt_s  = 1'b0;
    if (start) begin
      state_nxt_s = PACK;
    end else begin
      case (state_r)
        IDLE:    state_nxt_s = IDLE;
        PACK:    state_nxt_s = flush ? DRAIN : PACK;
        DRAIN: begin
          if (fifo_empty_s) begin
            state_nxt_s = IDLE;
            done_nxt_s  = 1'b1;
          end else begin
            state_nxt_s = DRAIN;
          end
        end
        default: state_nxt_s = IDLE;
      endcase
    end
  end

  // FSM outputs and write-port presentation of the FIFO head.
  always_comb begin
    busy         = (state_r != IDLE);
    done         = done_r;
    fifo_ovrflow = ovf_r;
    wr_addr      = wr_addr_r;
    wr_en        = !fifo_empty_s;
    if (!fifo_empty_s) begin
      wr_data = head_s[31:0];
      wr_be   = head_s[35:32];
    end else begin
      wr_data = 32'h0;
      wr_be   = 4'h0;
    end
  end

  // Packer lane, staged bytes, FIFO pointers, write address and overflow flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      lane_r    <= 2'd0;
      bytes_r   <= 24'h0;
      rd_ptr_r  <= '0;
      wr_ptr_r  <= '0;
      count_r   <= '0;
      wr_addr_r <= '0;
      ovf_r     <= 1'b0;
    end else if (start) begin
      lane_r    <= 2'd0;
      bytes_r   <= 24'h0;
      rd_ptr_r  <= '0;
      wr_ptr_r  <= '0;
      count_r   <= '0;
      wr_addr_r <= base_addr;
      ovf_r     <= 1'b0;
    end else begin
      lane_r  <= lane_nxt_s;
      bytes_r <= word_s[23:0];
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r  <= rd_ptr_r + PTR_W'(1);
        wr_addr_r <= wr_addr_r + ADDR_WIDTH'(1);
      end
      case ({push_ok_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
      if (overflow_s) begin
        ovf_r <= 1'b1;
      end
    end
  end

  // FIFO storage; contents need no reset because occupancy is tracked by count_r.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= push_word_s;
    end
  end

`ifdef RESULT_PACKER_BYTECNT_EN
  logic [ADDR_WIDTH+1:0] bc_r;
  logic [ADDR_WIDTH+2:0] bc_sum_s;

  assign bc_sum_s   = {1'b0, bc_r} + (ADDR_WIDTH+3)'(popcount4(wr_be));
  assign byte_count = bc_r;

  // Saturating count of bytes written.
  always_ff @(posedge clk) begin
    if (reset || start) begin
      bc_r <= '0;
    end else if (pop_s) begin
      bc_r <= bc_sum_s[ADDR_WIDTH+2] ? '1 : bc_sum_s[ADDR_WIDTH+1:0];
    end
  end
`endif

endmodule

// File: tb/tb_result_packer.sv
// Self-checking bench for result_packer: constant vector table, directed corner
// sequences, and randomized traffic against a queue-based reference model.
module tb_result_packer;
  localparam int AW    = 16;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset, start, result_valid, flush, wr_ready;
  logic [AW-1:0] base_addr, wr_addr;
  logic [7:0]    result_data;
  logic          wr_en, busy, done, fifo_ovrflow;
  logic [31:0]   wr_data;
  logic [3:0]    wr_be;
`ifdef RESULT_PACKER_BYTECNT_EN
  logic [AW+1:0] byte_count;
`endif

  result_packer #(.ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .result_data(result_data), .result_valid(result_valid), .flush(flush),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .wr_ready(wr_ready), .busy(busy), .done(done), .fifo_ovrflow(fifo_ovrflow)
`ifdef RESULT_PACKER_BYTECNT_EN
    , .byte_count(byte_count)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int done_cnt = 0;

  typedef struct { logic [31:0] d; logic [3:0] be; } word_t;
  typedef struct { logic [AW-1:0] a; logic [31:0] d; logic [3:0] be; } xfer_t;
  xfer_t got[$];

  // Reference model: spec-level state kept as plain variables and a word queue.
  int          m_state;  // 0 idle, 1 pack, 2 drain
  int          m_lane;
  logic [7:0]  m_bytes [4];
  word_t       m_q[$];
  logic [AW-1:0] m_addr;
  bit          m_ovf, m_done;
  longint      m_bc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic chk_word(input string name, input int idx, input logic [AW-1:0] a,
                          input logic [31:0] d, input logic [3:0] be);
    if (idx < got.size()) chk(name, {got[idx].a, got[idx].d, got[idx].be}, {a, d, be});
    else begin
      checks++;
      $display("FAIL %s: got no write %0d expected %0h", name, idx, {a, d, be});
    end
  endtask

  task automatic model_step(input bit st, input logic [AW-1:0] base, input bit v,
                            input logic [7:0] d, input bit fl, input bit rdy);
    int    pre;
    bit    xfer, have;
    word_t w, popped;
    pre  = m_q.size();
    xfer = (pre > 0) && rdy;
    have = 1'b0;
    if (st) begin
      m_q.delete(); m_lane = 0; m_addr = base; m_ovf = 1'b0;
      m_state = 1; m_done = 1'b0; m_bc = 0;
    end else begin
      m_done = (m_state == 2) && (pre == 0);
      if (xfer) begin
        popped = m_q.pop_front();
        m_addr = m_addr + 16'd1;
        m_bc   = m_bc + $countones(popped.be);
        if (m_bc > ((64'd1 << (AW + 2)) - 1)) m_bc = (64'd1 << (AW + 2)) - 1;
      end
      if (m_state == 1) begin
        if (v) begin
          m_bytes[m_lane] = d;
          m_lane++;
          if (m_lane == 4) begin
            w.d = {m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]};
            w.be = 4'hF; have = 1'b1; m_lane = 0;
          end
        end
        if (fl && m_lane > 0) begin
          w.d = 32'h0;
          for (int i = 0; i < m_lane; i++) w.d[8*i +: 8] = m_bytes[i];
          w.be = 4'((1 << m_lane) - 1); have = 1'b1; m_lane = 0;
        end
      end
      if (have) begin
        if (pre == DEPTH && !xfer) m_ovf = 1'b1;
        else m_q.push_back(w);
      end
      if (m_state == 1 && fl) m_state = 2;
      else if (m_state == 2 && pre == 0) m_state = 0;
    end
  endtask

  task automatic check_model();
    chk("wr_en", wr_en, m_q.size() > 0);
    chk("wr_addr", wr_addr, m_addr);
    chk("wr_data", wr_data, (m_q.size() > 0) ? m_q[0].d : 32'h0);
    chk("wr_be", wr_be, (m_q.size() > 0) ? m_q[0].be : 4'h0);
    chk("busy", busy, m_state != 0);
    chk("done", done, m_done);
    chk("fifo_ovrflow", fifo_ovrflow, m_ovf);
`ifdef RESULT_PACKER_BYTECNT_EN
    chk("byte_count", byte_count, m_bc);
`endif
  endtask

  // One clock: drive inputs after the falling edge, step the model, check after the next falling edge.
  task automatic cycle(input bit st, input logic [AW-1:0] base, input bit v,
                       input logic [7:0] d, input bit fl, input bit rdy);
    start = st; base_addr = base; result_valid = v; result_data = d; flush = fl; wr_ready = rdy;
    #1;
    if (wr_en && rdy && !st) got.push_back('{wr_addr, wr_data, wr_be});
    model_step(st, base, v, d, fl, rdy);
    @(posedge clk);
    @(negedge clk);
    check_model();
    if (done) done_cnt++;
  endtask

  task automatic send(input logic [7:0] d, input bit rdy);
    cycle(1'b0, '0, 1'b1, d, 1'b0, rdy);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, 8'h00, 1'b0, 1'b1);
  endtask

  typedef struct {
    bit st; logic [AW-1:0] base; bit v; logic [7:0] d;
    bit e_en; logic [AW-1:0] e_addr; logic [31:0] e_data; logic [3:0] e_be; bit e_busy;
  } vec_t;
  vec_t tbl [11];

  initial begin
    tbl[0]  = '{1'b1, 16'h0100, 1'b0, 8'h00, 1'b0, 16'h0000, 32'h0, 4'h0, 1'b0};
    tbl[1]  = '{1'b0, 16'h0000, 1'b1, 8'h01, 1'b0, 16'h0100, 32'h0, 4'h0, 1'b1};
    tbl[2]  = '{1'b0, 16'h0000, 1'b1, 8'h02, 1'b0, 16'h0100, 32'h0, 4'h0, 1'b1};
    tbl[3]  = '{1'b0, 16'h0000, 1'b1, 8'h03, 1'b0, 16'h0100, 32'h0, 4'h0, 1'b1};
    tbl[4]  = '{1'b0, 16'h0000, 1'b1, 8'h04, 1'b0, 16'h0100, 32'h0, 4'h0, 1'b1};
    tbl[5]  = '{1'b0, 16'h0000, 1'b1, 8'h05, 1'b1, 16'h0100, 32'h04030201, 4'hF, 1'b1};
    tbl[6]  = '{1'b0, 16'h0000, 1'b1, 8'h06, 1'b0, 16'h0101, 32'h0, 4'h0, 1'b1};
    tbl[7]  = '{1'b0, 16'h0000, 1'b1, 8'h07, 1'b0, 16'h0101, 32'h0, 4'h0, 1'b1};
    tbl[8]  = '{1'b0, 16'h0000, 1'b1, 8'h08, 1'b0, 16'h0101, 32'h0, 4'h0, 1'b1};
    tbl[9]  = '{1'b0, 16'h0000, 1'b0, 8'h00, 1'b1, 16'h0101, 32'h08070605, 4'hF, 1'b1};
    tbl[10] = '{1'b0, 16'h0000, 1'b0, 8'h00, 1'b0, 16'h0102, 32'h0, 4'h0, 1'b1};

    reset = 1'b1; start = 1'b0; base_addr = '0; result_valid = 1'b0;
    result_data = 8'h00; flush = 1'b0; wr_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    m_state = 0; m_lane = 0; m_addr = '0; m_ovf = 1'b0; m_done = 1'b0; m_bc = 0;
    check_model();

    // Vector table: two full words from base 0x0100.
    foreach (tbl[i]) begin
      chk($sformatf("tbl%0d_en", i), wr_en, tbl[i].e_en);
      chk($sformatf("tbl%0d_addr", i), wr_addr, tbl[i].e_addr);
      chk($sformatf("tbl%0d_data", i), wr_data, tbl[i].e_data);
      chk($sformatf("tbl%0d_be", i), wr_be, tbl[i].e_be);
      chk($sformatf("tbl%0d_busy", i), busy, tbl[i].e_busy);
      cycle(tbl[i].st, tbl[i].base, tbl[i].v, tbl[i].d, 1'b0, 1'b1);
    end

    // Six bytes then flush: full word plus 2-byte partial, single done pulse.
    got.delete(); done_cnt = 0;
    cycle(1'b1, 16'h0300, 1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) send(8'h11 + 8'(i), 1'b1);
    cycle(1'b0, '0, 1'b0, 8'h00, 1'b1, 1'b1);
    idle(10);
    chk("t2_writes", got.size(), 2);
    chk_word("t2_w0", 0, 16'h0300, 32'h14131211, 4'hF);
    chk_word("t2_w1", 1, 16'h0301, 32'h00001615, 4'h3);
    chk("t2_done_count", done_cnt, 1);
    chk("t2_busy_after", busy, 1'b0);

    // Stalled write port while 20 bytes arrive: 4 words kept, overflow flagged.
    got.delete();
    cycle(1'b1, 16'h0400, 1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) send(8'h20 + 8'(i), 1'b0);
    chk("t3_ovrflow", fifo_ovrflow, 1'b1);
    idle(10);
    chk("t3_writes", got.size(), 4);
    chk_word("t3_w0", 0, 16'h0400, 32'h23222120, 4'hF);
    chk_word("t3_w1", 1, 16'h0401, 32'h27262524, 4'hF);
    chk_word("t3_w2", 2, 16'h0402, 32'h2B2A2928, 4'hF);
    chk_word("t3_w3", 3, 16'h0403, 32'h2F2E2D2C, 4'hF);

    // Address wrap at the top of the word space.
    got.delete();
    cycle(1'b1, 16'hFFFF, 1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) send(8'h31 + 8'(i), 1'b1);
    idle(4);
    chk("t4_writes", got.size(), 2);
    chk_word("t4_w0", 0, 16'hFFFF, 32'h34333231, 4'hF);
    chk_word("t4_w1", 1, 16'h0000, 32'h38373635, 4'hF);

    // Restart mid-word discards the stale bytes.
    got.delete();
    cycle(1'b1, 16'h0500, 1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) send(8'hC1 + 8'(i), 1'b1);
    cycle(1'b1, 16'h0200, 1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) send(8'hA0 + 8'(i), 1'b1);
    cycle(1'b0, '0, 1'b0, 8'h00, 1'b1, 1'b1);
    idle(8);
    chk("t5_writes", got.size(), 1);
    chk_word("t5_w0", 0, 16'h0200, 32'hA3A2A1A0, 4'hF);

    // Byte and flush together at lane 3: only the full word, then done.
    got.delete(); done_cnt = 0;
    cycle(1'b1, 16'h0600, 1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) send(8'h51 + 8'(i), 1'b1);
    cycle(1'b0, '0, 1'b1, 8'h54, 1'b1, 1'b1);
    idle(8);
    chk("t6_writes", got.size(), 1);
    chk_word("t6_w0", 0, 16'h0600, 32'h54535251, 4'hF);
    chk("t6_done_count", done_cnt, 1);

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      cycle((i == 0) || ($urandom_range(0, 99) == 0), 16'($urandom),
            $urandom_range(0, 3) != 0, 8'($urandom),
            $urandom_range(0, 24) == 0, $urandom_range(0, 2) != 0);
    end
    idle(12);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
